// File: rtl/ofm_pool_requant.sv
// Post-processing for the conv engine OFM stream: bias subtract, ReLU,
// 1-D max-pool over POOL valid samples, round/saturate requant to OUT_W bits.
module ofm_pool_requant #(
   parameter int unsigned DATA_W    = 13,
   parameter int unsigned OUT_W     = 8,
   parameter int unsigned POOL      = 4,
   parameter int unsigned SHIFT     = 5,
   parameter int unsigned FRAME_LEN = 48
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] bias,
   input  logic              flush,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              frame_done,
   output logic              sat_flag
);

   localparam int unsigned SCNT_W = $clog2(FRAME_LEN + 1);
   localparam int unsigned WCNT_W = $clog2(POOL + 1);
   localparam logic [DATA_W:0] RND     = (DATA_W+1)'(1) << (SHIFT - 1);
   localparam logic [DATA_W:0] OUT_MAX = (DATA_W+1)'((2 ** OUT_W) - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_d;
   logic [DATA_W-1:0]   bias_r, bias_r_d;
   logic [SCNT_W-1:0]   sample_cnt, sample_cnt_d;
   logic [WCNT_W-1:0]   win_cnt, win_cnt_d;
   logic [DATA_W-1:0]   max_r, max_r_d;
   logic                out_valid_d, frame_done_d, sat_flag_d;
   logic [OUT_W-1:0]    out_data_d;

   logic [DATA_W-1:0]   bias_sel;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   relu_v, cand, pool_max;
   logic [DATA_W:0]     rnd_sum, q;
   logic                clamp;
   logic [OUT_W-1:0]    q_sat;
   logic [SCNT_W-1:0]   samp_next;
   logic [WCNT_W-1:0]   win_next;
   logic                close_win, last_samp, emit;

   // Datapath: relu, running max including the current sample, requant
   always_comb begin
      bias_sel  = (state == IDLE) ? bias : bias_r;
      diff      = {1'b0, in_data} - {1'b0, bias_sel};
      relu_v    = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
      cand      = (state == IDLE || win_cnt == '0) ? relu_v
                : ((relu_v > max_r) ? relu_v : max_r);
      pool_max  = in_valid ? cand : max_r;
      rnd_sum   = {1'b0, pool_max} + RND;
      q         = rnd_sum >> SHIFT;
      clamp     = (q > OUT_MAX);
      q_sat     = clamp ? OUT_W'(OUT_MAX) : OUT_W'(q);
      samp_next = sample_cnt + SCNT_W'(1);
      win_next  = win_cnt + WCNT_W'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state;
      bias_r_d     = bias_r;
      sample_cnt_d = sample_cnt;
      win_cnt_d    = win_cnt;
      max_r_d      = max_r;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      out_data_d   = out_data;
      sat_flag_d   = sat_flag;
      close_win    = 1'b0;
      last_samp    = 1'b0;
      emit         = 1'b0;

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_d      = RUN;
               bias_r_d     = bias;
               sample_cnt_d = SCNT_W'(1);
               win_cnt_d    = WCNT_W'(1);
               max_r_d      = relu_v;
               sat_flag_d   = 1'b0;
            end
         end
         RUN: begin
            if (in_valid) begin
               sample_cnt_d = samp_next;
               win_cnt_d    = win_next;
               max_r_d      = cand;
            end
            close_win = in_valid && (win_next == WCNT_W'(POOL));
            last_samp = in_valid && (samp_next == SCNT_W'(FRAME_LEN));
            // A flush still emits a partial window if it holds any sample
            emit = close_win || (flush && (in_valid || win_cnt != '0));
            if (emit) begin
               out_valid_d = 1'b1;
               out_data_d  = q_sat;
               win_cnt_d   = '0;
               if (clamp) sat_flag_d = 1'b1;
            end
            if (last_samp || flush) begin
               frame_done_d = 1'b1;
               state_d      = IDLE;
               sample_cnt_d = '0;
               win_cnt_d    = '0;
               max_r_d      = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bias_r     <= '0;
         sample_cnt <= '0;
         win_cnt    <= '0;
         max_r      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         state      <= state_d;
         bias_r     <= bias_r_d;
         sample_cnt <= sample_cnt_d;
         win_cnt    <= win_cnt_d;
         max_r      <= max_r_d;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
         frame_done <= frame_done_d;
         sat_flag   <= sat_flag_d;
      end
   end

endmodule

// File: tb/tb_ofm_pool_requant.sv
// Directed bench for ofm_pool_requant with hand-computed expected outputs.
module tb_ofm_pool_requant;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [12:0] in_data = '0;
   logic [12:0] bias = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        frame_done;
   logic        sat_flag;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ofm_pool_requant dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .bias(bias), .flush(flush), .out_valid(out_valid), .out_data(out_data),
      .frame_done(frame_done), .sat_flag(sat_flag)
   );

   // One clock of stimulus; outputs are observed 1 time unit after the edge
   task automatic cyc(input logic v, input logic [12:0] d, input logic f);
      in_valid = v; in_data = d; flush = f;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, out_data, frame_done, sat_flag} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b d=%0d fd=%b sat=%b, want all 0",
                  out_valid, out_data, frame_done, sat_flag);
      end
      @(negedge clk); rst_n = 1'b1;
      cyc(0, 0, 1); // flush in IDLE must be ignored
      vectors++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_flush: got v=%b fd=%b, want 0 0", out_valid, frame_done);
      end
   endtask

   task automatic test_basic();
      bias = 13'd0;
      cyc(1, 100, 0); cyc(1, 300, 0); cyc(1, 50, 0);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++; $display("FAIL basic_early: out_valid=%b want 0", out_valid);
      end
      cyc(1, 200, 0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd9 || frame_done !== 1'b0 || sat_flag !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_window: got v=%b d=%0d fd=%b sat=%b, want 1 9 0 0",
                  out_valid, out_data, frame_done, sat_flag);
      end
      cyc(0, 0, 0);
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 8'd9) begin
         miscompares++;
         $display("FAIL basic_hold: got v=%b d=%0d, want 0 9", out_valid, out_data);
      end
      // flush right after a window closed: frame_done alone
      cyc(0, 0, 1);
      vectors++;
      if (out_valid !== 1'b0 || frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_empty: got v=%b fd=%b, want 0 1", out_valid, frame_done);
      end
      cyc(0, 0, 0);
      vectors++;
      if (frame_done !== 1'b0) begin
         miscompares++; $display("FAIL fd_pulse: frame_done=%b want 0", frame_done);
      end
   endtask

   task automatic test_gapped();
      logic [12:0] samples [4];
      samples[0] = 13'd400; samples[1] = 13'd600;
      samples[2] = 13'd1000; samples[3] = 13'd450;
      bias = 13'd500;
      for (int i = 0; i < 4; i++) begin
         cyc(1, samples[i], 0);
         if (i == 0) bias = 13'd0; // captured bias must persist for the frame
         if (i < 3) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++; $display("FAIL gap_early%0d: out_valid=%b want 0", i, out_valid);
            end
            repeat (3) cyc(0, 0, 0);
         end
      end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd16) begin
         miscompares++;
         $display("FAIL gapped_window: got v=%b d=%0d, want 1 16", out_valid, out_data);
      end
      cyc(0, 0, 1);
   endtask

   task automatic test_saturation();
      bias = 13'd0;
      repeat (4) cyc(1, 13'd8191, 0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd255 || sat_flag !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_window: got v=%b d=%0d sat=%b, want 1 255 1",
                  out_valid, out_data, sat_flag);
      end
      cyc(0, 0, 1);
      repeat (3) cyc(0, 0, 0);
      vectors++;
      if (sat_flag !== 1'b1) begin
         miscompares++; $display("FAIL sat_sticky: sat_flag=%b want 1", sat_flag);
      end
      cyc(1, 0, 0);
      vectors++;
      if (sat_flag !== 1'b0) begin
         miscompares++; $display("FAIL sat_clear: sat_flag=%b want 0", sat_flag);
      end
      cyc(0, 0, 1); // partial window of one zero sample
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd0 || frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_flush: got v=%b d=%0d fd=%b, want 1 0 1",
                  out_valid, out_data, frame_done);
      end
   endtask

   task automatic test_full_frame();
      bias = 13'd0;
      for (int k = 0; k < 48; k++) begin
         cyc(1, 13'(32 * k), 0);
         if (k % 4 == 3) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(k) || frame_done !== (k == 47)) begin
               miscompares++;
               $display("FAIL frame_out%0d: got v=%b d=%0d fd=%b, want 1 %0d %b",
                        k, out_valid, out_data, frame_done, k, (k == 47));
            end
         end else begin
            vectors++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
               miscompares++;
               $display("FAIL frame_quiet%0d: got v=%b fd=%b, want 0 0", k, out_valid, frame_done);
            end
         end
      end
      // back-to-back frame with new bias; coincident flush on first sample ignored
      bias = 13'd100;
      cyc(1, 13'd132, 1);
      vectors++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_start: got v=%b fd=%b, want 0 0", out_valid, frame_done);
      end
      bias = 13'd0;
      cyc(1, 13'd100, 1); // same-cycle sample included: max(32,0)=32 -> 1
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd1 || frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_flush: got v=%b d=%0d fd=%b, want 1 1 1",
                  out_valid, out_data, frame_done);
      end
   endtask

   task automatic test_flush();
      bias = 13'd0;
      cyc(1, 13'd64, 0); cyc(1, 13'd32, 0);
      cyc(0, 0, 1);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd2 || frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_partial: got v=%b d=%0d fd=%b, want 1 2 1",
                  out_valid, out_data, frame_done);
      end
      cyc(0, 0, 0);
      vectors++;
      if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_pulse: got v=%b fd=%b, want 0 0", out_valid, frame_done);
      end
   endtask

   task automatic test_reset_mid();
      bias = 13'd0;
      repeat (3) cyc(1, 13'd8000, 0);
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({out_valid, out_data, frame_done, sat_flag} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got v=%b d=%0d fd=%b sat=%b, want all 0",
                  out_valid, out_data, frame_done, sat_flag);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 13'd32, 0);
         if (i < 3) begin
            vectors++;
            if (out_valid !== 1'b0) begin
               miscompares++; $display("FAIL reset_stale%0d: out_valid=%b want 0", i, out_valid);
            end
         end
      end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'd1 || sat_flag !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_window: got v=%b d=%0d sat=%b, want 1 1 0",
                  out_valid, out_data, sat_flag);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_saturation();
      test_full_frame();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
